// File: rtl/multi_cycle_div_if.sv
// Handshake/data bundle for multi_cycle_div: the requester drives it through master, the divider through slave.
// Outputs are registered in the divider except div_busy, which follows the FSM state directly.
interface multi_cycle_div_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic             div_signed;
  logic             div_cancel;
  logic [WIDTH-1:0] div_src1;
  logic [WIDTH-1:0] div_src2;
  logic             div_busy;
  logic             div_done;
  logic             div_by_zero;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;

  modport master (
    output div_start, div_signed, div_cancel, div_src1, div_src2,
    input  div_busy, div_done, div_by_zero, div_quot, div_rem
  );

  modport slave (
    input  div_start, div_signed, div_cancel, div_src1, div_src2,
    output div_busy, div_done, div_by_zero, div_quot, div_rem
  );
endinterface

// File: rtl/multi_cycle_div.sv
// Restoring signed/unsigned divider, one quotient bit per cycle; result WIDTH+1 edges after accept (1 edge on /0).
// No backpressure: a start is taken only in IDLE, starts while busy are dropped, cancel aborts CALC silently.
module multi_cycle_div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  multi_cycle_div_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH:0]   prem_q;
  logic [WIDTH-1:0] shq_q;
  logic [WIDTH-1:0] dsor_q;
  logic [CW-1:0]    cnt_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH-1:0] src1_abs;
  logic [WIDTH-1:0] src2_abs;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   prem_d;
  logic [WIDTH-1:0] shq_d;

  assign src1_abs = (bus.div_signed && bus.div_src1[WIDTH-1]) ? -bus.div_src1 : bus.div_src1;
  assign src2_abs = (bus.div_signed && bus.div_src2[WIDTH-1]) ? -bus.div_src2 : bus.div_src2;

  // shq_q shifts dividend bits out of the top while quotient bits enter at the bottom
  assign trial  = {prem_q, shq_q[WIDTH-1]} - {2'b00, dsor_q};
  assign prem_d = trial[WIDTH+1] ? {prem_q[WIDTH-1:0], shq_q[WIDTH-1]} : trial[WIDTH:0];
  assign shq_d  = {shq_q[WIDTH-2:0], ~trial[WIDTH+1]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      prem_q  <= '0;
      shq_q   <= '0;
      dsor_q  <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.div_start) begin
            qneg_q <= (bus.div_src1[WIDTH-1] ^ bus.div_src2[WIDTH-1]) & bus.div_signed;
            rneg_q <= bus.div_src1[WIDTH-1] & bus.div_signed;
            shq_q  <= src1_abs;
            dsor_q <= src2_abs;
            prem_q <= '0;
            cnt_q  <= CW'(WIDTH - 1);
            if (bus.div_src2 == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              quot_q  <= '0;
              rem_q   <= bus.div_src1;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.div_cancel) begin
            state_q <= IDLE;
          end else begin
            prem_q <= prem_d;
            shq_q  <= shq_d;
            cnt_q  <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
              // last bit: apply signs so DONE presents final values
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= qneg_q ? -shq_d : shq_d;
              rem_q   <= rneg_q ? -prem_d[WIDTH-1:0] : prem_d[WIDTH-1:0];
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.div_busy    = (state_q != IDLE);
  assign bus.div_done    = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.div_quot    = quot_q;
  assign bus.div_rem     = rem_q;
endmodule

// File: tb/tb_multi_cycle_div.sv
// Directed and randomized checks of multi_cycle_div against an arithmetic reference model.
module tb_multi_cycle_div;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multi_cycle_div_if #(.WIDTH(W)) dif ();

  multi_cycle_div #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // C-style truncating division; remainder takes the dividend's sign
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    if (b == '0) begin
      q = '0;
      r = a;
      z = 1'b1;
      return;
    end
    z = 1'b0;
    if (sgn) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input bit noise);
    logic [W-1:0] eq, er;
    logic         ez;
    int           n;
    bit           steady;
    ref_div(a, b, sgn, eq, er, ez);
    dif.div_src1   = a;
    dif.div_src2   = b;
    dif.div_signed = sgn;
    dif.div_start  = 1'b1;
    tick;
    dif.div_start = 1'b0;
    chk({tag, " busy_after_accept"}, W'(dif.div_busy), W'(1));
    n      = 0;
    steady = 1'b1;
    while (dif.div_done !== 1'b1 && n < 100) begin
      if (dif.div_by_zero !== 1'b0 || dif.div_busy !== 1'b1) steady = 1'b0;
      if (noise) begin
        dif.div_start  = 1'($urandom_range(0, 1));
        dif.div_signed = 1'($urandom_range(0, 1));
        dif.div_src1   = $urandom;
        dif.div_src2   = $urandom;
      end
      tick;
      n++;
    end
    dif.div_start = 1'b0;
    chk({tag, " edges_to_done"}, W'(n), (b == '0) ? W'(0) : W'(W));
    chk({tag, " quot"}, dif.div_quot, eq);
    chk({tag, " rem"}, dif.div_rem, er);
    chk({tag, " by_zero"}, W'(dif.div_by_zero), W'(ez));
    chk({tag, " busy_steady"}, W'(steady), W'(1));
    tick;
    chk({tag, " done_one_cycle"}, W'(dif.div_done), W'(0));
    chk({tag, " busy_released"}, W'(dif.div_busy), W'(0));
    chk({tag, " by_zero_cleared"}, W'(dif.div_by_zero), W'(0));
    tick;
    chk({tag, " quot_held"}, dif.div_quot, eq);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    dif.div_start  = 1'b0;
    dif.div_signed = 1'b0;
    dif.div_cancel = 1'b0;
    dif.div_src1   = '0;
    dif.div_src2   = '0;
    #3;
    chk("reset busy", W'(dif.div_busy), W'(0));
    chk("reset done", W'(dif.div_done), W'(0));
    chk("reset by_zero", W'(dif.div_by_zero), W'(0));
    chk("reset quot", dif.div_quot, W'(0));
    chk("reset rem", dif.div_rem, W'(0));
    @(negedge clk);
    resetn = 1'b1;
    tick;

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 1'b0);
    run_op("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_op("u-7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("u5_0", 32'd5, 32'd0, 1'b0, 1'b0);
    run_op("s5_0", 32'd5, 32'd0, 1'b1, 1'b0);
    run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("u100_7b", 32'd100, 32'd7, 1'b0, 1'b1);

    // cancel mid-CALC together with a competing start
    dif.div_src1  = 32'd100;
    dif.div_src2  = 32'd7;
    dif.div_signed = 1'b0;
    dif.div_start = 1'b1;
    tick;
    dif.div_start = 1'b0;
    repeat (10) tick;
    chk("cancel quot_held_mid", dif.div_quot, 32'd14);
    dif.div_cancel = 1'b1;
    dif.div_start  = 1'b1;
    dif.div_src1   = 32'd1;
    dif.div_src2   = 32'd1;
    tick;
    dif.div_cancel = 1'b0;
    dif.div_start  = 1'b0;
    chk("cancel busy", W'(dif.div_busy), W'(0));
    chk("cancel done", W'(dif.div_done), W'(0));
    chk("cancel quot", dif.div_quot, 32'd14);
    chk("cancel rem", dif.div_rem, 32'd2);
    tick;
    chk("cancel start_ignored", W'(dif.div_busy), W'(0));
    run_op("u9_3", 32'd9, 32'd3, 1'b0, 1'b0);

    // asynchronous reset in the middle of an operation
    dif.div_src1  = 32'd1000;
    dif.div_src2  = 32'd3;
    dif.div_start = 1'b1;
    tick;
    dif.div_start = 1'b0;
    repeat (14) tick;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst busy", W'(dif.div_busy), W'(0));
    chk("midrst done", W'(dif.div_done), W'(0));
    chk("midrst by_zero", W'(dif.div_by_zero), W'(0));
    chk("midrst quot", dif.div_quot, W'(0));
    chk("midrst rem", dif.div_rem, W'(0));
    @(negedge clk);
    resetn = 1'b1;
    tick;
    chk("midrst idle", W'(dif.div_busy), W'(0));
    run_op("post_rst", 32'd1000, 32'd3, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = 32'($urandom);
      endcase
      run_op("rnd", ra, rb, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
